// File: rtl/bus1to2_pkg.sv
// Shared definitions for the single-master, two-slave bus demultiplexer:
// FSM state encoding, error read-data default, timeout counter sizing and
// the address window match used by the decoder.
package bus_pkg;

   // Demux states. The decoder also returns one of SEL1/SEL2/DERR as the
   // state to enter after the IDLE decode cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL1 = 2'd1,
      SEL2 = 2'd2,
      DERR = 2'd3
   } state_t;

   // Read data presented on decode errors and timeouts.
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // The timeout counter is never narrower than this.
   localparam int unsigned TCNT_MIN_W = 8;

   // Width needed for a counter that must reach TIMEOUT-1, with a floor.
   function automatic int unsigned tcnt_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout + 1);
      return (w < TCNT_MIN_W) ? TCNT_MIN_W : w;
   endfunction

   // A target claims an address when the masked address equals its base.
   function automatic logic addr_match(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/bus1to2_if.sv
// Native valid/ready memory bus. The initiator side uses the master modport,
// the target side uses the slave modport. wstrb == 0 marks a read.
interface bus1to2_if;
   logic        valid;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   modport master (
      output valid,
      output addr,
      output wdata,
      output wstrb,
      input  ready,
      input  rdata
   );

   modport slave (
      input  valid,
      input  addr,
      input  wdata,
      input  wstrb,
      output ready,
      output rdata
   );
endinterface

// File: rtl/bus1to2_addr_decode.sv
// Pure combinational two-target address decoder. Slave 1 is checked first,
// so it owns any address that both windows would claim. Addresses that match
// neither window map to the error state.
module bus_addr_decode
   import bus_pkg::*;
#(
   parameter logic [31:0] S1_BASE = 32'h0000_0000,
   parameter logic [31:0] S1_MASK = 32'hF000_0000,
   parameter logic [31:0] S2_BASE = 32'h1000_0000,
   parameter logic [31:0] S2_MASK = 32'hF000_0000
) (
   input  logic [31:0] addr,
   output state_t      tgt
);

   logic hit1;
   logic hit2;

   assign hit1 = addr_match(addr, S1_BASE, S1_MASK);
   assign hit2 = addr_match(addr, S2_BASE, S2_MASK);

   // Priority select of the state that follows the decode cycle.
   always_comb begin
      tgt = DERR;
      if (hit1) begin
         tgt = SEL1;
      end else if (hit2) begin
         tgt = SEL2;
      end
   end

endmodule

// File: rtl/bus1to2.sv
// One-master to two-slave address demultiplexer. A request seen in IDLE is
// decoded once and the selection is held until the transaction ends: the
// selected slave completes it, the per-transaction timeout forces an error
// completion, the master withdraws, or reset abandons it. Address, write
// data and strobes fan out to both slaves unconditionally; only the valids
// are steered.
module bus1to2
   import bus_pkg::*;
#(
   parameter logic [31:0] S1_BASE   = 32'h0000_0000,
   parameter logic [31:0] S1_MASK   = 32'hF000_0000,
   parameter logic [31:0] S2_BASE   = 32'h1000_0000,
   parameter logic [31:0] S2_MASK   = 32'hF000_0000,
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   bus1to2_if.slave    m,
   bus1to2_if.master   s1,
   bus1to2_if.master   s2,
   output logic        err
);

   localparam int unsigned TCNT_W = tcnt_width(TIMEOUT);
   // TIMEOUT == 0 turns the watchdog off entirely.
   localparam bit TO_EN = (TIMEOUT != 0);
   // Last count value before the forced completion.
   localparam logic [TCNT_W-1:0] TLAST =
      TCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   state_t            dec_tgt;
   logic [TCNT_W-1:0] tcnt;
   logic [TCNT_W-1:0] tcnt_nxt;
   logic              sel_ready;
   logic [31:0]       sel_rdata;

   bus_addr_decode #(
      .S1_BASE (S1_BASE),
      .S1_MASK (S1_MASK),
      .S2_BASE (S2_BASE),
      .S2_MASK (S2_MASK)
   ) u_decode (
      .addr (m.addr),
      .tgt  (dec_tgt)
   );

   // Payload goes to both slaves; a slave only acts when its valid is high.
   assign s1.addr  = m.addr;
   assign s1.wdata = m.wdata;
   assign s1.wstrb = m.wstrb;
   assign s2.addr  = m.addr;
   assign s2.wdata = m.wdata;
   assign s2.wstrb = m.wstrb;

   // Response of the currently selected slave; the other slave is ignored.
   always_comb begin
      sel_ready = s1.ready;
      sel_rdata = s1.rdata;
      if (state == SEL2) begin
         sel_ready = s2.ready;
         sel_rdata = s2.rdata;
      end
   end

   // State and timeout counter; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   // Next state, valid steering, master response and error pulse.
   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      s1.valid  = 1'b0;
      s2.valid  = 1'b0;
      m.ready   = 1'b0;
      m.rdata   = '0;
      err       = 1'b0;

      unique case (state)
         IDLE: begin
            tcnt_nxt = '0;
            if (m.valid) begin
               state_nxt = dec_tgt;
            end
         end

         SEL1, SEL2: begin
            if (state == SEL1) begin
               s1.valid = m.valid;
            end else begin
               s2.valid = m.valid;
            end
            m.rdata = sel_rdata;
            // A withdrawn request is dropped quietly, even if the slave answers.
            m.ready = m.valid & sel_ready;

            if (!m.valid) begin
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end else if (sel_ready) begin
               // Completion beats a timeout reached in the same cycle.
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end else if (TO_EN && (tcnt == TLAST)) begin
               state_nxt = DERR;
               tcnt_nxt  = '0;
            end else begin
               tcnt_nxt = tcnt + TCNT_W'(1);
            end
         end

         DERR: begin
            m.ready   = 1'b1;
            m.rdata   = ERR_RDATA;
            err       = 1'b1;
            state_nxt = IDLE;
            tcnt_nxt  = '0;
         end

         default: begin
            state_nxt = IDLE;
            tcnt_nxt  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_bus1to2.sv
// Bench for bus1to2. Every cycle's expected outputs are derived at transaction
// level (target, slave wait, withdraw/reset point) and queued; one compare
// process checks the DUT against the queue each cycle. Directed cases pin the
// expectations with hand-computed literals, then randomized traffic follows.
module tb_bus1to2;

   localparam int          TO   = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic resetn;
   logic err;

   always #5 clk = ~clk;

   bus1to2_if m_bus ();
   bus1to2_if s1_bus ();
   bus1to2_if s2_bus ();

   bus1to2 #(
      .S1_BASE   (32'h0000_0000),
      .S1_MASK   (32'hF000_0000),
      .S2_BASE   (32'h1000_0000),
      .S2_MASK   (32'hF000_0000),
      .TIMEOUT   (TO),
      .ERR_RDATA (ERRD)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .m      (m_bus),
      .s1     (s1_bus),
      .s2     (s2_bus),
      .err    (err)
   );

   typedef struct {
      logic        s1v;
      logic        s2v;
      logic        mr;
      logic        er;
      logic [31:0] rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   exp_t exp_q[$];
   exp_t ce;

   int n_checks = 0;
   int n_err    = 0;

   int          cnt_s1v = 0, cnt_s2v = 0, cnt_mr = 0, cnt_err = 0;
   logic [31:0] last_rd = '0;
   int          cyc_n = 0, mr_cyc = -100, prev_mr_cyc = -100;
   int          b_s1, b_s2, b_mr, b_er, b_cyc;
   logic        fan_ok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: one queued expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ce = exp_q.pop_front();
         chk("s1_valid", {31'b0, s1_bus.valid}, {31'b0, ce.s1v});
         chk("s2_valid", {31'b0, s2_bus.valid}, {31'b0, ce.s2v});
         chk("m_ready",  {31'b0, m_bus.ready},  {31'b0, ce.mr});
         chk("err",      {31'b0, err},          {31'b0, ce.er});
         chk("m_rdata",  m_bus.rdata, ce.rd);
         fan_ok = (s1_bus.addr === ce.addr) && (s2_bus.addr === ce.addr) &&
                  (s1_bus.wdata === ce.wdata) && (s2_bus.wdata === ce.wdata) &&
                  (s1_bus.wstrb === ce.wstrb) && (s2_bus.wstrb === ce.wstrb);
         chk("fanout", {31'b0, fan_ok}, 32'd1);
         if (s1_bus.valid === 1'b1) cnt_s1v++;
         if (s2_bus.valid === 1'b1) cnt_s2v++;
         if (err === 1'b1) cnt_err++;
         if (m_bus.ready === 1'b1) begin
            cnt_mr++;
            last_rd     = m_bus.rdata;
            prev_mr_cyc = mr_cyc;
            mr_cyc      = cyc_n;
         end
         cyc_n++;
      end
   end

   // Drive one cycle of inputs and queue the outputs that cycle must show.
   task automatic cyc(input logic mv, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic r1, input logic r2,
                      input logic [31:0] d1, input logic [31:0] d2, input logic rn,
                      input logic e1, input logic e2, input logic emr, input logic eer,
                      input logic [31:0] erd);
      exp_t e;
      @(posedge clk);
      #1;
      m_bus.valid  = mv;
      m_bus.addr   = a;
      m_bus.wdata  = wd;
      m_bus.wstrb  = ws;
      s1_bus.ready = r1;
      s1_bus.rdata = d1;
      s2_bus.ready = r2;
      s2_bus.rdata = d2;
      resetn       = rn;
      e.s1v = e1; e.s2v = e2; e.mr = emr; e.er = eer; e.rd = erd;
      e.addr = a; e.wdata = wd; e.wstrb = ws;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      cyc(1'b0, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
          $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   // One transaction. tgt: 0 unmapped, 1/2 slave. w: cycles the selected
   // slave keeps ready low before answering. drop_at / rst_at: selected-phase
   // cycle (1-based) where the master withdraws or reset is asserted, or -1.
   task automatic txn(input int tgt, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input int w, input int drop_at,
                      input int rst_at, input logic [31:0] rdv);
      logic [31:0] d1, d2, ds;
      logic        r1, r2, rs;
      // Request cycle: decode only, nothing visible yet.
      cyc(1'b1, a, wd, ws, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'b1,
          1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (tgt == 0) begin
         cyc(1'b1, a, wd, ws, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'b1,
             1'b0, 1'b0, 1'b1, 1'b1, ERRD);
         return;
      end
      for (int k = 1; k <= TO + 1; k++) begin
         d1 = $urandom; d2 = $urandom;
         r1 = 1'($urandom); r2 = 1'($urandom);
         if (k == TO + 1) begin
            // Slave stayed silent for TO cycles: forced error completion.
            cyc(1'b1, a, wd, ws, r1, r2, d1, d2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ERRD);
            return;
         end
         rs = (k == w + 1) && (k != drop_at) && (k != rst_at);
         ds = rs ? rdv : $urandom;
         if (tgt == 1) begin r1 = rs; d1 = ds; end
         else          begin r2 = rs; d2 = ds; end
         if (k == drop_at) begin
            cyc(1'b0, a, wd, ws, r1, r2, d1, d2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ds);
            return;
         end
         cyc(1'b1, a, wd, ws, r1, r2, d1, d2, (k == rst_at) ? 1'b0 : 1'b1,
             tgt == 1, tgt == 2, rs, 1'b0, ds);
         if (rs || (k == rst_at)) return;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic snap();
      b_s1 = cnt_s1v; b_s2 = cnt_s2v; b_mr = cnt_mr; b_er = cnt_err; b_cyc = cyc_n;
   endtask

   initial begin
      resetn = 1'b0;
      m_bus.valid = 1'b0; m_bus.addr = '0; m_bus.wdata = '0; m_bus.wstrb = '0;
      s1_bus.ready = 1'b0; s1_bus.rdata = '0;
      s2_bus.ready = 1'b0; s2_bus.rdata = '0;
      @(posedge clk);
      // Held in reset: everything quiet, m_rdata zero.
      repeat (2) cyc(1'b0, $urandom, $urandom, 4'($urandom), 1'b1, 1'b1, $urandom, $urandom,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      idle();
      settle();
      chk("reset_no_ready", cnt_mr, 0);

      // Read from slave 1 with two wait cycles.
      snap();
      txn(1, 32'h0000_0040, 32'h0, 4'h0, 2, -1, -1, 32'h1234_5678);
      settle();
      chk("rd1_s1v_cycles", cnt_s1v - b_s1, 3);
      chk("rd1_s2v_cycles", cnt_s2v - b_s2, 0);
      chk("rd1_ready_pulses", cnt_mr - b_mr, 1);
      chk("rd1_rdata", last_rd, 32'h1234_5678);
      chk("rd1_err", cnt_err - b_er, 0);

      // Write to slave 2, zero-wait.
      snap();
      txn(2, 32'h1000_0008, 32'hAABB_CCDD, 4'b0011, 0, -1, -1, 32'h0);
      settle();
      chk("wr2_latency", mr_cyc - b_cyc, 1);
      chk("wr2_s1v_cycles", cnt_s1v - b_s1, 0);
      chk("wr2_s2v_cycles", cnt_s2v - b_s2, 1);

      // Unmapped address.
      snap();
      txn(0, 32'h2000_0000, 32'h0, 4'h0, 0, -1, -1, 32'h0);
      settle();
      chk("unm_latency", mr_cyc - b_cyc, 1);
      chk("unm_err", cnt_err - b_er, 1);
      chk("unm_rdata", last_rd, 32'hDEAD_BEEF);
      chk("unm_slave_valids", (cnt_s1v - b_s1) + (cnt_s2v - b_s2), 0);

      // Slave 1 never answers: timeout, then a normal slave 2 read.
      snap();
      txn(1, 32'h0000_1000, 32'h0, 4'h0, 100, -1, -1, 32'h0);
      settle();
      chk("to_s1v_cycles", cnt_s1v - b_s1, 4);
      chk("to_err", cnt_err - b_er, 1);
      chk("to_rdata", last_rd, 32'hDEAD_BEEF);
      chk("to_latency", mr_cyc - b_cyc, 5);
      snap();
      txn(2, 32'h1000_0010, 32'h0, 4'h0, 1, -1, -1, 32'hCAFE_0002);
      settle();
      chk("after_to_rdata", last_rd, 32'hCAFE_0002);
      chk("after_to_err", cnt_err - b_er, 0);

      // Reset during a slave 2 wait, then a slave 1 request at address 0.
      snap();
      txn(2, 32'h1000_0100, 32'h0, 4'h0, 10, -1, 2, 32'h0);
      txn(1, 32'h0000_0000, 32'h0, 4'h0, 0, -1, -1, 32'h5555_AAAA);
      settle();
      chk("rst_s2v_cycles", cnt_s2v - b_s2, 2);
      chk("rst_s1v_cycles", cnt_s1v - b_s1, 1);
      chk("rst_ready_pulses", cnt_mr - b_mr, 1);
      chk("rst_rdata", last_rd, 32'h5555_AAAA);

      // Back-to-back zero-wait reads: one bubble between ready pulses.
      snap();
      txn(1, 32'h0000_0200, 32'h0, 4'h0, 0, -1, -1, 32'h1111_0001);
      txn(2, 32'h1000_0200, 32'h0, 4'h0, 0, -1, -1, 32'h2222_0002);
      settle();
      chk("b2b_pulses", cnt_mr - b_mr, 2);
      chk("b2b_spacing", mr_cyc - prev_mr_cyc, 2);
      chk("b2b_rdata", last_rd, 32'h2222_0002);

      // Ready arrives exactly at the timeout threshold: completion wins.
      snap();
      txn(1, 32'h0000_0300, 32'h0, 4'h0, TO - 1, -1, -1, 32'h0BAD_F00D);
      settle();
      chk("thr_err", cnt_err - b_er, 0);
      chk("thr_s1v_cycles", cnt_s1v - b_s1, 4);
      chk("thr_rdata", last_rd, 32'h0BAD_F00D);

      // Master withdraws mid-wait: no completion.
      snap();
      txn(2, 32'h1000_0400, 32'h0, 4'h0, 3, 2, -1, 32'h0);
      settle();
      chk("drop_ready_pulses", cnt_mr - b_mr, 0);
      chk("drop_err", cnt_err - b_er, 0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         int          tgt, w, dr, ra, ng;
         logic [31:0] a;
         tgt = $urandom_range(0, 2);
         case (tgt)
            0:       a = {4'($urandom_range(2, 15)), 28'($urandom)};
            1:       a = {4'h0, 28'($urandom)};
            default: a = {4'h1, 28'($urandom)};
         endcase
         w  = $urandom_range(0, TO + 2);
         dr = -1;
         ra = -1;
         if (w >= 1 && $urandom_range(0, 9) == 0)
            dr = $urandom_range(1, (w < TO) ? w : TO);
         else if (w >= 1 && $urandom_range(0, 19) == 0)
            ra = $urandom_range(1, (w < TO) ? w : TO);
         txn(tgt, a, $urandom, 4'($urandom), w, dr, ra, $urandom);
         ng = $urandom_range(0, 2);
         for (int g = 0; g < ng; g++) idle();
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      settle();
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/bus1to2.md
Name: bus1to2

Overview:
- Address-decoding demultiplexer for the native valid/ready memory bus; one master port fans out to two slave ports.
- Counterpart of the 2-master arbiter: where that merges initiators, this splits one initiator across two targets (e.g. RAM and MMIO).
- Selection is latched per transaction. Unmapped addresses get an error response. A per-transaction timeout keeps a dead slave from hanging the core.

Parameters:
- S1_BASE, 32'h0000_0000, slave 1 match value.
- S1_MASK, 32'hF000_0000, slave 1 address mask (match when (addr & S1_MASK) == S1_BASE).
- S2_BASE, 32'h1000_0000, slave 2 match value.
- S2_MASK, 32'hF000_0000, slave 2 address mask.
- TIMEOUT, 255, cycles in S1/S2 without s_ready before forced error completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on any error completion.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- resetn, input, 1, reset: synchronous, active-low.
- m_valid, input, 1, master request; held until m_ready.
- m_ready, output, 1, one-cycle transfer-complete pulse.
- m_addr, input, 32, master address.
- m_rdata, output, 32, read data; valid when m_ready is high.
- m_wdata, input, 32, write data.
- m_wstrb, input, 4, byte strobes; 0 = read.
- s1_valid, output, 1, slave 1 request.
- s1_ready, input, 1, slave 1 completion.
- s1_addr, output, 32, slave 1 address.
- s1_rdata, input, 32, slave 1 read data.
- s1_wdata, output, 32, slave 1 write data.
- s1_wstrb, output, 4, slave 1 byte strobes.
- s2_*, same as s1_*, slave 2 equivalents.
- err, output, 1, one-cycle pulse on decode error or timeout.

Behaviour:
- State register states: IDLE, SEL1, SEL2, DERR.
- Timeout counter: tcnt, 8 bits minimum, sized to hold TIMEOUT.
- Reset:
  - resetn low at a posedge gives state=IDLE, tcnt=0.
  - Hence from that edge: m_ready=0, s1_valid=0, s2_valid=0, err=0, m_rdata=0.
  - Reset mid-transaction abandons it silently; no ready pulse is issued.
- Fan-out:
  - s1/s2 addr, wdata and wstrb are always driven from m_*, combinationally.
  - Only the valids are gated.
- IDLE:
  - All valids are 0 and m_ready=0.
  - If m_valid is high, decode m_addr and register the next state:
    - match S1 gives SEL1; checked first, so S1 wins on overlap;
    - else match S2 gives SEL2;
    - else DERR.
  - Decode adds exactly 1 cycle of latency.
- SEL1:
  - s1_valid = m_valid; m_ready = s1_ready; m_rdata = s1_rdata.
  - On s1_ready: go to IDLE, tcnt=0.
- SEL2: mirror of SEL1 using the s2_* ports.
- Timeout in SEL1/SEL2:
  - tcnt increments each cycle without ready.
  - When tcnt == TIMEOUT-1 and still no ready:
    - the next cycle is a forced completion, handled as DERR;
    - slave valid drops in that cycle.
- DERR:
  - m_ready=1, m_rdata=ERR_RDATA, err=1, for exactly one cycle; then IDLE.
  - No slave valid is asserted.
- Master drops m_valid in SEL1/SEL2 (protocol violation): go to IDLE, tcnt=0, no m_ready.
- Slave ready in the same cycle as the timeout threshold: the slave completion wins and err stays 0.
- Back-to-back transactions: one IDLE bubble cycle between them. Minimum latency is 2 cycles from m_valid to m_ready with a zero-wait slave.
- m_rdata is 0 in IDLE.
- s_ready from the non-selected slave is ignored.

Decomposition:
- Shared package bus_pkg, containing:
  - state encoding localparams: IDLE=2'd0, SEL1=2'd1, SEL2=2'd2, DERR=2'd3;
  - default ERR_RDATA constant;
  - address-match function (addr, base, mask).
- Optional sub-module bus_addr_decode (pure combinational match, 2 targets, priority). This keeps bus1to2 focused on the FSM and timeout.

Test Plan:
- Read to slave 1: m_addr=0x0000_0040, wstrb=0, s1_ready after 2 wait cycles, rdata 0x1234_5678 → s1_valid high for 3 cycles, s2_valid never high, single m_ready pulse with m_rdata=0x1234_5678, err=0.
- Write to slave 2: m_addr=0x1000_0008, wstrb=4'b0011, wdata 0xAABB_CCDD, s2_ready immediately → s2 sees the same addr/wdata/wstrb, m_ready 2 cycles after m_valid, s1_valid=0 throughout.
- Unmapped address 0x2000_0000 → no slave valid, m_ready=1 with m_rdata=0xDEAD_BEEF and err=1 on the 2nd cycle.
- Timeout: TIMEOUT=4, slave 1 never ready → s1_valid high for 4 cycles then low, m_ready+err pulse with ERR_RDATA; a following request to slave 2 completes normally.
- Reset mid-transaction: resetn low during SEL2 wait → after that edge s2_valid=0, m_ready=0; after resetn high, a new request to 0x0000_0000 goes to slave 1.
- Back-to-back: slave 1 read then slave 2 read with zero-wait slaves → exactly one idle cycle between the m_ready pulses, correct rdata for each.
